// File: rtl/pwm_channel_driver.sv
// Multi-channel PWM pin driver with period-boundary double-buffered duty values.
// New duties arrive over valid/ready and take effect only at the next period start.
module pwm_channel_driver #(
  parameter int PWM_INTERVAL = 1200,
  parameter int NUM_CH       = 3,
  parameter int DUTY_W       = $clog2(PWM_INTERVAL),
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH*DUTY_W-1:0] duty_in,
  input  logic                     duty_valid,
  output logic                     duty_ready,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start
);

  localparam int CNT_W = $clog2(PWM_INTERVAL);
  // One extra bit so a duty equal to PWM_INTERVAL still compares as "always on".
  localparam int CMP_W = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PWM_INTERVAL - 1);
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]         counter;
  logic [NUM_CH*DUTY_W-1:0] active;
  logic [NUM_CH*DUTY_W-1:0] pending;
  logic                     pending_flag;
  logic                     apply;
  logic [NUM_CH-1:0]        on;

  assign duty_ready = !pending_flag;

  always_comb begin
    apply = !enable || (counter == LAST);
  end

  always_comb begin
    on = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      on[i] = enable && (CMP_W'(counter) < CMP_W'(active[i*DUTY_W +: DUTY_W]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter      <= '0;
      active       <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
      pwm_out      <= {NUM_CH{IDLE_LVL}};
      period_start <= 1'b0;
    end else begin
      if (!enable || counter == LAST) begin
        counter <= '0;
      end else begin
        counter <= counter + CNT_W'(1);
      end

      // Apply and transfer are mutually exclusive on pending_flag, so a transfer
      // landing on an apply edge only fills pending and waits one more period.
      if (apply && pending_flag) begin
        active       <= pending;
        pending_flag <= 1'b0;
      end
      if (duty_valid && !pending_flag) begin
        pending      <= duty_in;
        pending_flag <= 1'b1;
      end

      pwm_out      <= on ^ {NUM_CH{IDLE_LVL}};
      period_start <= enable && (counter == '0);
    end
  end

endmodule

// File: tb/tb_pwm_channel_driver.sv
// Directed bench for pwm_channel_driver with PWM_INTERVAL=10, NUM_CH=3, active-low pins.
module tb_pwm_channel_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] duty_in;
  logic        duty_valid;
  logic        duty_ready;
  logic [2:0]  pwm_out;
  logic        period_start;

  int passed = 0;
  int total  = 0;
  int ph      = 0;  // counter value the next rising edge will see
  int ph_seen = 0;  // counter value seen by the edge just taken

  always #5 clk = ~clk;

  pwm_channel_driver #(
    .PWM_INTERVAL(10),
    .NUM_CH(3),
    .DUTY_W(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .duty_in(duty_in),
    .duty_valid(duty_valid),
    .duty_ready(duty_ready),
    .pwm_out(pwm_out),
    .period_start(period_start)
  );

  function automatic logic [11:0] pack(input int d2, input int d1, input int d0);
    return {4'(d2), 4'(d1), 4'(d0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (counter %0d)", tag, obs, exp, ph_seen);
  endtask

  task automatic tick();
    @(posedge clk);
    ph_seen = ph;
    if (rst || !enable) ph = 0;
    else ph = (ph == 9) ? 0 : ph + 1;
    #1;
  endtask

  // Expected pins for a running channel set: low (on) while counter < duty.
  task automatic chk_pwm(input string tag, input int d2, input int d1, input int d0);
    logic [3:0] exp;
    exp = {ph_seen == 0, !(ph_seen < d2), !(ph_seen < d1), !(ph_seen < d0)};
    chk(tag, {period_start, pwm_out}, exp);
  endtask

  task automatic run(input string tag, input int n, input int d2, input int d1, input int d0);
    for (int k = 0; k < n; k++) begin
      tick();
      chk_pwm(tag, d2, d1, d0);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; duty_valid = 1'b0; duty_in = '0;
    #1;
    chk("reset_state", {period_start, duty_ready, pwm_out}, 5'b0_1_111);
    #11 rst = 1'b0;

    for (int k = 0; k < 50; k++) begin
      tick();
      chk("idle", {period_start, duty_ready, pwm_out}, 5'b0_1_111);
    end

    // Load while disabled: transfer, then apply on the next disabled edge.
    duty_in = pack(0, 10, 3); duty_valid = 1'b1;
    tick();
    chk("load_ready_low", duty_ready, 0);
    duty_valid = 1'b0;
    tick();
    chk("disabled_apply_ready", duty_ready, 1);
    chk("disabled_out", pwm_out, 3'b111);
    enable = 1'b1;
    run("basic", 20, 0, 10, 3);

    // Update mid-period at counter 5.
    run("pre_update", 5, 0, 10, 3);
    duty_in = pack(0, 10, 7); duty_valid = 1'b1;
    tick();
    chk_pwm("xfer_edge", 0, 10, 3);
    chk("ready_drop", duty_ready, 0);
    duty_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_pwm("old_period", 0, 10, 3);
      chk("ready_held", duty_ready, 0);
    end
    tick();
    chk_pwm("old_period_end", 0, 10, 3);
    chk("ready_back", duty_ready, 1);
    run("new_duty", 10, 0, 10, 7);

    // Back-pressure: A taken at counter 0, B held until ready returns.
    duty_in = pack(0, 10, 5); duty_valid = 1'b1;
    tick();
    chk_pwm("bp_first_xfer", 0, 10, 7);
    chk("bp_ready_low", duty_ready, 0);
    duty_in = pack(0, 10, 2);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_pwm("bp_hold", 0, 10, 7);
    end
    chk("bp_ready_back", duty_ready, 1);
    tick();
    chk_pwm("bp_a_start", 0, 10, 5);
    chk("bp_second_taken", duty_ready, 0);
    duty_valid = 1'b0;
    run("bp_a_period", 9, 0, 10, 5);
    run("bp_b_period", 10, 0, 10, 2);

    // Transfer on the counter==9 edge, clamp value 15.
    run("pre_clamp", 9, 0, 10, 2);
    duty_in = pack(0, 10, 15); duty_valid = 1'b1;
    tick();
    chk_pwm("clamp_xfer_edge", 0, 10, 2);
    chk("clamp_ready_low", duty_ready, 0);
    duty_valid = 1'b0;
    run("clamp_old_period", 10, 0, 10, 2);
    run("clamp_full", 10, 0, 10, 15);

    // Async reset at counter 4 with a value pending.
    duty_in = pack(6, 6, 6); duty_valid = 1'b1;
    tick();
    chk_pwm("rst_pre_xfer", 0, 10, 15);
    chk("rst_pending", duty_ready, 0);
    duty_valid = 1'b0;
    run("rst_pre_run", 3, 0, 10, 15);
    #2 rst = 1'b1;
    ph = 0;
    #1;
    chk("async_reset_out", {period_start, duty_ready, pwm_out}, 5'b0_1_111);
    #1 rst = 1'b0;
    run("post_reset_off", 20, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_channel_driver.md
Name: pwm_channel_driver

Overview:
- Consumes the duty values produced by the brightness/fade sequencers and drives the physical PWM pins, one per channel (default 3 channels: R, G, B).
- Double-buffers duty values so a new value only takes effect at a PWM period boundary. This prevents glitched or partial pulses.
- Accepts new duty values through a valid/ready handshake.
- Emits a period-start strobe so upstream sequencers can align their updates.

Parameters:
- PWM_INTERVAL, 1200: PWM period in clk cycles (100 us at 12 MHz). Minimum 2.
- NUM_CH, 3: number of PWM channels.
- DUTY_W, $clog2(PWM_INTERVAL): width of one channel's duty value.
- ACTIVE_LOW, 1: 1 means an on-phase drives the pin 0 (board LEDs are active-low). 0 means an on-phase drives 1.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1 = PWM running; 0 = counter held at 0 and outputs forced inactive.
- duty_in  input  NUM_CH*DUTY_W  packed duty values; channel i occupies bits [i*DUTY_W +: DUTY_W].
- duty_valid  input  1  duty_in holds a new set of values.
- duty_ready  output  1  block can accept duty_in (pending buffer empty).
- pwm_out  output  NUM_CH  registered PWM pins.
- period_start  output  1  one-cycle pulse, aligned with pwm_out, marking the first cycle of a period.

Behaviour:
- Reset (async, rst=1):
  - period counter = 0.
  - active duty registers = 0.
  - pending duty registers = 0; pending flag = 0.
  - pwm_out = {NUM_CH{ACTIVE_LOW}} (all inactive).
  - period_start = 0.
  - duty_ready = 1.
- Period counter:
  - Width $clog2(PWM_INTERVAL). When enable=1 it counts 0..PWM_INTERVAL-1 and wraps to 0.
  - When enable=0 it is synchronously held at 0.
- Handshake:
  - duty_ready = !pending_flag (combinational).
  - A transfer occurs on a clk edge where duty_valid && duty_ready. All NUM_CH values are captured into pending and pending_flag is set.
  - duty_valid while duty_ready=0 is ignored. The source must hold duty_in and duty_valid until the transfer.
- Apply point: pending is copied into active, and pending_flag is cleared, on the edge where either condition holds:
  - enable=1 and counter==PWM_INTERVAL-1, or
  - enable=0.
  
  The first period after the wrap therefore uses the new values.
- Simultaneous transfer and apply:
  - A transfer can only occur when pending_flag=0.
  - If a transfer lands on an apply edge, the new value goes to pending only and is applied at the following apply point.
  - There is no bypass from duty_in straight to active.
- Compare:
  - on_i = enable && (counter < active_i).
  - active_i >= PWM_INTERVAL (clamp) gives 100% on.
  - active_i = 0 gives 100% off.
  - The comparison is unsigned at DUTY_W+1 bits so that PWM_INTERVAL is representable.
- Output:
  - pwm_out[i] <= on_i ^ ACTIVE_LOW, registered.
  - Latency: counter value c at cycle t is reflected on pwm_out at t+1.
  - period_start <= enable && (counter==0), registered, so it shares the 1-cycle latency.
- enable falling mid-period:
  - The counter returns to 0 on the next edge.
  - pwm_out goes inactive one cycle later.
  - Any pending value is applied immediately (apply point while disabled).
- enable rising: the counter starts from 0, and period_start pulses one cycle after the first enabled cycle.
- rst asserted mid-period: all state clears immediately (async). Any pending value is lost.

Test Plan:
Use PWM_INTERVAL=10, NUM_CH=3, ACTIVE_LOW=1 for all scenarios.
- Reset then idle: rst pulse, enable=0 -> pwm_out=3'b111, duty_ready=1, period_start=0 for 50 cycles.
- Basic duty: load {ch2=0, ch1=10, ch0=3} while disabled, then enable=1 -> per 10-cycle period, ch0 is low (on) for exactly 3 cycles starting with the period_start cycle, ch1 is low for all 10, ch2 is never low. period_start repeats every 10 cycles.
- Boundary-synchronous update: running with ch0=3; at counter=5, transfer ch0=7 -> duty_ready drops to 0; the current period still shows 3 on-cycles; the next period shows 7; duty_ready returns to 1 the cycle after the apply edge.
- Back-pressure: hold duty_valid=1 with two different values across a boundary -> the second value is captured only after duty_ready returns to 1, and no value is dropped or applied mid-period.
- Clamp and transfer at the apply edge: transfer ch0=15 on the counter==9 edge -> the following period still uses the old value; the period after that shows ch0 on for all 10 cycles.
- Async reset mid-operation: assert rst at counter=4 with a pending value -> pwm_out=3'b111 without waiting for a clk edge. After release with enable=1, all channels stay off until a new transfer is applied.
